// File: rtl/ace_ccu_snoop_collector.sv
// Snoop response collector for one coherent transaction.
// Gathers CR responses from the snooped ports of a group, merges them into a
// single CRRESP, then forwards the cacheline from the lowest-indexed port that
// signalled DataTransfer while draining any redundant CD bursts from the rest.
module ace_ccu_snoop_collector #(
    parameter int NoPorts   = 4,
    parameter int DataWidth = 64,
    parameter int LineBeats = 2,
    parameter int PortIdxW  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_valid_i,
    output logic                           start_ready_o,
    input  logic [NoPorts-1:0]             start_mask_i,
    input  logic [NoPorts-1:0]             cr_valid_i,
    output logic [NoPorts-1:0]             cr_ready_o,
    input  logic [5*NoPorts-1:0]           cr_resp_i,
    input  logic [NoPorts-1:0]             cd_valid_i,
    output logic [NoPorts-1:0]             cd_ready_o,
    input  logic [DataWidth*NoPorts-1:0]   cd_data_i,
    input  logic [NoPorts-1:0]             cd_last_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [4:0]                     resp_o,
    output logic [PortIdxW-1:0]            resp_port_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic [DataWidth-1:0]           data_o,
    output logic                           data_last_o,
    output logic                           beat_err_o
);

    // Beat counter saturates at LineBeats so overlong bursts stay flagged.
    localparam int CntW = $clog2(LineBeats + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESP    = 2'd2,
        DATA    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NoPorts-1:0]    pend_q, pend_d;
    logic [NoPorts-1:0]    dt_q, dt_d;
    logic [4:0]            agg_q, agg_d;
    logic [PortIdxW-1:0]   sel_q, sel_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  beat_err_q, beat_err_d;
    logic [CntW-1:0]       cnt_q [NoPorts];
    logic [CntW-1:0]       cnt_d [NoPorts];

    logic                  in_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_pend;
    logic [DataWidth-1:0]  sel_data;
    logic [NoPorts-1:0]    cd_hs;

    // Lowest port index with its bit set; zero when the vector is empty.
    function automatic logic [PortIdxW-1:0] lowest_set(input logic [NoPorts-1:0] v);
        logic [PortIdxW-1:0] idx;
        idx = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (v[i]) idx = PortIdxW'(i);
        end
        return idx;
    endfunction

    assign in_data       = (state_q == DATA);
    assign start_ready_o = (state_q == IDLE);
    assign cr_ready_o    = (state_q == COLLECT) ? pend_q : '0;
    assign resp_valid_o  = resp_valid_q;
    assign resp_o        = agg_q;
    assign resp_port_o   = sel_q;
    assign beat_err_o    = beat_err_q;
    assign cd_hs         = cd_valid_i & cd_ready_o;

    // Combinational CD pass-through: forward the selected port, drain the others.
    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_pend   = 1'b0;
        sel_data   = '0;
        cd_ready_o = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (PortIdxW'(i) == sel_q) begin
                sel_valid = cd_valid_i[i];
                sel_last  = cd_last_i[i];
                sel_pend  = dt_q[i];
                sel_data  = cd_data_i[i*DataWidth +: DataWidth];
            end
            if (in_data && dt_q[i]) begin
                cd_ready_o[i] = (PortIdxW'(i) == sel_q) ? data_ready_i : 1'b1;
            end
        end
        data_valid_o = in_data && sel_pend && sel_valid;
        data_o       = (in_data && sel_pend) ? sel_data : '0;
        data_last_o  = in_data && sel_pend && sel_last;
    end

    // Next-state logic for the round FSM, response merge and length check.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        dt_d         = dt_q;
        agg_d        = agg_q;
        sel_d        = sel_q;
        resp_valid_d = resp_valid_q;
        beat_err_d   = 1'b0;
        for (int i = 0; i < NoPorts; i++) cnt_d[i] = cnt_q[i];

        case (state_q)
            IDLE: begin
                if (start_valid_i) begin
                    pend_d = start_mask_i;
                    agg_d  = '0;
                    dt_d   = '0;
                    if (start_mask_i == '0) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        sel_d        = '0;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                for (int i = 0; i < NoPorts; i++) begin
                    if (cr_valid_i[i] && pend_q[i]) begin
                        pend_d[i] = 1'b0;
                        agg_d     = agg_d | cr_resp_i[5*i +: 5];
                        dt_d[i]   = cr_resp_i[5*i];
                    end
                end
                if (pend_d == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    sel_d        = lowest_set(dt_d);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    for (int i = 0; i < NoPorts; i++) cnt_d[i] = '0;
                    state_d = (dt_q != '0) ? DATA : IDLE;
                end
            end
            DATA: begin
                for (int i = 0; i < NoPorts; i++) begin
                    if (cd_hs[i]) begin
                        if (cd_last_i[i]) begin
                            dt_d[i] = 1'b0;
                            if (cnt_q[i] != CntW'(LineBeats - 1)) beat_err_d = 1'b1;
                        end else begin
                            if (cnt_q[i] >= CntW'(LineBeats)) beat_err_d = 1'b1;
                            if (cnt_q[i] != CntW'(LineBeats)) cnt_d[i] = cnt_q[i] + CntW'(1);
                        end
                    end
                end
                if (dt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset aborts any round in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            dt_q         <= '0;
            agg_q        <= '0;
            sel_q        <= '0;
            resp_valid_q <= 1'b0;
            beat_err_q   <= 1'b0;
            for (int i = 0; i < NoPorts; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            dt_q         <= dt_d;
            agg_q        <= agg_d;
            sel_q        <= sel_d;
            resp_valid_q <= resp_valid_d;
            beat_err_q   <= beat_err_d;
            for (int i = 0; i < NoPorts; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_ace_ccu_snoop_collector.sv
// Scoreboard bench for ace_ccu_snoop_collector (4 ports, 64-bit data, 2 beats/line).
module tb_ace_ccu_snoop_collector;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int PW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_valid_i;
    logic              start_ready_o;
    logic [NP-1:0]     start_mask_i;
    logic [NP-1:0]     cr_valid_i;
    logic [NP-1:0]     cr_ready_o;
    logic [5*NP-1:0]   cr_resp_i;
    logic [NP-1:0]     cd_valid_i = '0;
    logic [NP-1:0]     cd_ready_o;
    logic [DW*NP-1:0]  cd_data_i = '0;
    logic [NP-1:0]     cd_last_i = '0;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [4:0]        resp_o;
    logic [PW-1:0]     resp_port_o;
    logic              data_valid_o;
    logic              data_ready_i = 1'b1;
    logic [DW-1:0]     data_o;
    logic              data_last_o;
    logic              beat_err_o;

    int total = 0;
    int bad   = 0;

    logic [64:0]   src_q [NP][$];
    logic [6:0]    exp_resp_q [$];
    logic [64:0]   exp_data_q [$];
    logic [NP-1:0] hs;
    int            dr_mode  = 0;
    int            err_cnt  = 0;
    int            err_base = 0;
    bit            mirror_en = 1'b0;
    int            exp_sel  = 0;

    ace_ccu_snoop_collector #(
        .NoPorts(NP), .DataWidth(DW), .LineBeats(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_valid_i(start_valid_i), .start_ready_o(start_ready_o), .start_mask_i(start_mask_i),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o), .resp_port_o(resp_port_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o), .data_last_o(data_last_o),
        .beat_err_o(beat_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [NP-1:0] m);
        start_valid_i = 1'b1;
        start_mask_i  = m;
        tick();
        start_valid_i = 1'b0;
        start_mask_i  = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!start_ready_o && n < 50);
        chk({tag, "_idle"}, start_ready_o, 1);
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_srdy"}, start_ready_o, 1);
        chk({tag, "_crrdy"}, cr_ready_o, 0);
        chk({tag, "_cdrdy"}, cd_ready_o, 0);
        chk({tag, "_rvld"}, resp_valid_o, 0);
        chk({tag, "_dvld"}, data_valid_o, 0);
        chk({tag, "_dlast"}, data_last_o, 0);
        chk({tag, "_berr"}, beat_err_o, 0);
        chk({tag, "_resp"}, resp_o, 0);
        chk({tag, "_rport"}, resp_port_o, 0);
        chk({tag, "_data"}, data_o, 0);
    endtask

    task automatic push_beat(input int port, input logic [63:0] d, input logic last, input bit fwd);
        src_q[port].push_back({last, d});
        if (fwd) exp_data_q.push_back({last, d});
    endtask

    // One-cycle round where only 'port' reports DataTransfer.
    task automatic run_single(input string tag, input int port, input logic [NP-1:0] mask);
        logic [5*NP-1:0] r;
        r = '0;
        r[port*5] = 1'b1;
        exp_resp_q.push_back({2'(port), 5'b00001});
        start(mask);
        cr_valid_i = mask;
        cr_resp_i  = r;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        wait_idle(tag);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_i) begin : mon
        logic [6:0]  er;
        logic [64:0] ed;
        hs = cd_valid_i & cd_ready_o;
        if (rst_ni === 1'b1) begin
            if (beat_err_o) err_cnt++;
            if (resp_valid_o && resp_ready_i) begin
                if (exp_resp_q.size() == 0) chk("resp_extra", 1, 0);
                else begin
                    er = exp_resp_q.pop_front();
                    chk("resp", resp_o, er[4:0]);
                    chk("resp_port", resp_port_o, er[6:5]);
                end
            end
            if (data_valid_o && data_ready_i) begin
                if (exp_data_q.size() == 0) chk("data_extra", 1, 0);
                else begin
                    ed = exp_data_q.pop_front();
                    chk("data", data_o, ed[63:0]);
                    chk("data_last", data_last_o, ed[64]);
                end
            end
            if (mirror_en && src_q[exp_sel].size() > 0)
                chk("rdy_mirror", cd_ready_o[exp_sel], data_ready_i);
        end
    end

    // CD source model and data_ready_i pattern generator.
    always @(posedge clk_i) begin
        logic [64:0] b;
        #2;
        for (int i = 0; i < NP; i++) begin
            if (hs[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                cd_valid_i[i]          = 1'b1;
                cd_data_i[i*DW +: DW]  = b[63:0];
                cd_last_i[i]           = b[64];
            end else begin
                cd_valid_i[i]          = 1'b0;
                cd_data_i[i*DW +: DW]  = '0;
                cd_last_i[i]           = 1'b0;
            end
        end
        case (dr_mode)
            1:       data_ready_i = ~data_ready_i;
            2:       data_ready_i = 1'b0;
            default: data_ready_i = 1'b1;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        start_valid_i = 1'b0;
        start_mask_i  = '0;
        cr_valid_i    = '0;
        cr_resp_i     = '0;
        resp_ready_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check_rst("rst");
        tick();
        rst_ni = 1'b1;
        tick();

        // Empty mask: response next cycle, no data phase.
        exp_resp_q.push_back({2'd0, 5'b00000});
        start(4'b0000);
        @(negedge clk_i);
        chk("t1_rvalid", resp_valid_o, 1);
        chk("t1_cdrdy", cd_ready_o, 0);
        tick();
        @(negedge clk_i);
        chk("t1_idle", start_ready_o, 1);
        chk("t1_dvld", data_valid_o, 0);
        tick();

        // Two ports answer together; unmasked port 0 is ignored.
        exp_resp_q.push_back({2'd0, 5'b11000});
        start(4'b1010);
        cr_valid_i = 4'b1011;
        cr_resp_i  = {5'b10000, 5'b00000, 5'b01000, 5'b11111};
        @(negedge clk_i);
        chk("t2_crrdy", cr_ready_o, 4'b1010);
        tick();
        cr_valid_i = 4'b0001;
        @(negedge clk_i);
        chk("t2_rvalid", resp_valid_o, 1);
        chk("t2_cdrdy", cd_ready_o, 0);
        tick();
        @(negedge clk_i);
        chk("t2_idle", start_ready_o, 1);
        chk("t2_unmasked", cr_ready_o, 0);
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        chk("t2_rq", exp_resp_q.size(), 0);

        // Ports 1 and 2 both carry dirty data; port 1 forwarded, port 2 drained.
        push_beat(1, 64'h1111_0000_0000_000a, 1'b0, 1'b1);
        push_beat(1, 64'h1111_0000_0000_000b, 1'b1, 1'b1);
        push_beat(2, 64'h2222_0000_0000_000c, 1'b0, 1'b0);
        push_beat(2, 64'h2222_0000_0000_000d, 1'b1, 1'b0);
        dr_mode = 2;
        exp_resp_q.push_back({2'd1, 5'b00101});
        start(4'b1111);
        cr_valid_i = 4'b1111;
        cr_resp_i  = {5'b00000, 5'b00101, 5'b00101, 5'b00000};
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        @(negedge clk_i);
        chk("t3_passdirty", resp_o[2], 1);
        tick();
        @(negedge clk_i);
        chk("t3_rdy_stall", cd_ready_o, 4'b0100);
        chk("t3_dvld_stall", data_valid_o, 1);
        tick();
        @(negedge clk_i);
        chk("t3_rdy_stall2", cd_ready_o, 4'b0100);
        tick();
        @(negedge clk_i);
        chk("t3_drained", cd_ready_o, 4'b0000);
        tick();
        dr_mode = 0;
        wait_idle("t3");
        chk("t3_dq", exp_data_q.size(), 0);
        chk("t3_src2", src_q[2].size(), 0);
        repeat (2) @(negedge clk_i);
        chk("t3_noerr", err_cnt, 0);
        tick();

        // Staggered CRs, stalled response, toggling data_ready_i.
        push_beat(0, 64'h0e0e_0e0e_0e0e_0e0e, 1'b0, 1'b1);
        push_beat(0, 64'h0f0f_0f0f_0f0f_0f0f, 1'b1, 1'b1);
        dr_mode      = 1;
        exp_sel      = 0;
        resp_ready_i = 1'b0;
        exp_resp_q.push_back({2'd0, 5'b00001});
        start(4'b0011);
        cr_valid_i = 4'b0010;
        cr_resp_i  = '0;
        @(negedge clk_i);
        tick();
        cr_valid_i = 4'b0001;
        cr_resp_i  = {15'b0, 5'b00001};
        @(negedge clk_i);
        chk("t4_pend", cr_ready_o, 4'b0001);
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t4_hold_v", resp_valid_o, 1);
            chk("t4_hold_r", resp_o, 5'b00001);
            tick();
        end
        resp_ready_i = 1'b1;
        tick();
        mirror_en = 1'b1;
        wait_idle("t4");
        mirror_en = 1'b0;
        dr_mode   = 0;
        chk("t4_dq", exp_data_q.size(), 0);
        chk("t4_rq", exp_resp_q.size(), 0);
        tick();

        // Short burst: last on beat 0.
        err_base = err_cnt;
        push_beat(0, 64'h0000_0000_0000_0666, 1'b1, 1'b1);
        run_single("t5", 0, 4'b0001);
        repeat (2) @(negedge clk_i);
        chk("t5_err", err_cnt - err_base, 1);
        chk("t5_dq", exp_data_q.size(), 0);
        tick();

        // Overlong burst: third beat and late last both flagged.
        err_base = err_cnt;
        push_beat(0, 64'h0000_0000_0000_0701, 1'b0, 1'b1);
        push_beat(0, 64'h0000_0000_0000_0702, 1'b0, 1'b1);
        push_beat(0, 64'h0000_0000_0000_0703, 1'b0, 1'b1);
        push_beat(0, 64'h0000_0000_0000_0704, 1'b1, 1'b1);
        run_single("t5b", 0, 4'b0001);
        repeat (2) @(negedge clk_i);
        chk("t5b_err", err_cnt - err_base, 2);
        chk("t5b_dq", exp_data_q.size(), 0);
        tick();

        // Reset during DATA after one beat, then a clean round.
        push_beat(0, 64'h0000_0000_0000_0a01, 1'b0, 1'b1);
        push_beat(0, 64'h0000_0000_0000_0a02, 1'b1, 1'b0);
        exp_resp_q.push_back({2'd0, 5'b00001});
        start(4'b0001);
        cr_valid_i = 4'b0001;
        cr_resp_i  = {15'b0, 5'b00001};
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        tick();
        @(negedge clk_i);
        chk("t6_dvld", data_valid_o, 1);
        tick();
        rst_ni = 1'b0;
        src_q[0].delete();
        exp_data_q.delete();
        @(negedge clk_i);
        check_rst("t6_rst");
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_rq", exp_resp_q.size(), 0);
        push_beat(2, 64'h0000_0000_0000_0b01, 1'b0, 1'b1);
        push_beat(2, 64'h0000_0000_0000_0b02, 1'b1, 1'b1);
        run_single("t6_after", 2, 4'b0100);
        chk("t6_dq", exp_data_q.size(), 0);
        chk("t6_rq2", exp_resp_q.size(), 0);
        repeat (2) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
